serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub.sv | 104 ++++++++++
 tb/tb_serial_sub.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bi one bit per clock, LSB first,
// and presents the registered difference and borrow-out with a one-cycle done pulse.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] d_q;
    logic             br_q;
    logic             bo_q;
    logic             busy_q;
    logic             done_q;
    logic [4:0]       cnt_q;

    logic             diff_d;
    logic             br_d;
    logic             last_d;
    logic [WIDTH-1:0] res_d;

    // One full-subtractor slice operating on the current LSBs of the shifters.
    assign diff_d = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    assign br_d   = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    assign res_d  = {diff_d, res_q[WIDTH-1:1]};
    assign last_d = (cnt_q == 5'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        br_q    <= bi;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    res_q  <= res_d;
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + 5'd1;
                    // Outputs update only here, so partial results never reach d.
                    if (last_d) begin
                        d_q     <= res_d;
                        bo_q    <= br_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign d    = d_q;
    assign bo   = bo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub at WIDTH=8.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
    logic         busy;
    logic         done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .bi     (bi),
        .d      (d),
        .bo     (bo),
        .busy   (busy),
        .done   (done)
    );

    // Launches one operation and observes a fixed 12-cycle window after the start edge.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic biv,
                          output int done_at, output int busy_cyc, output int pulses,
                          output int d_changes);
        logic [W-1:0] d0;
        done_at   = 0;
        busy_cyc  = 0;
        pulses    = 0;
        d_changes = 0;
        @(negedge clk);
        a = av; b = bv; bi = biv; start = 1'b1;
        d0 = d;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cyc++;
            if (done) begin
                pulses++;
                if (done_at == 0) done_at = k;
            end else if (pulses == 0 && d !== d0) begin
                d_changes++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; bi = 1'b0;
        #12;
        total_cnt++; if (d !== 8'h00) $display("FAIL reset_d got %h exp 00", d); else pass_cnt++;
        total_cnt++; if (bo !== 1'b0) $display("FAIL reset_bo got %b exp 0", bo); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_no_start got busy=%b done=%b exp 0/0", busy, done); else pass_cnt++;
        $display("reset: d=%h bo=%b busy=%b done=%b", d, bo, busy, done);
    endtask

    task automatic test_basic();
        int done_at, busy_cyc, pulses, d_changes;
        run_op(8'h05, 8'h03, 1'b0, done_at, busy_cyc, pulses, d_changes);
        total_cnt++; if (busy_cyc != 8) $display("FAIL basic_busy_cycles got %0d exp 8", busy_cyc); else pass_cnt++;
        total_cnt++; if (done_at != 9) $display("FAIL basic_done_latency got %0d exp 9", done_at); else pass_cnt++;
        total_cnt++; if (pulses != 1) $display("FAIL basic_done_pulses got %0d exp 1", pulses); else pass_cnt++;
        total_cnt++; if (d_changes != 0) $display("FAIL basic_d_early got %0d changes exp 0", d_changes); else pass_cnt++;
        total_cnt++; if (d !== 8'h02) $display("FAIL basic_d got %h exp 02", d); else pass_cnt++;
        total_cnt++; if (bo !== 1'b0) $display("FAIL basic_bo got %b exp 0", bo); else pass_cnt++;
        $display("basic: 05-03-0 -> d=%h bo=%b busy_cycles=%0d done_at=%0d", d, bo, busy_cyc, done_at);
    endtask

    task automatic test_borrow();
        logic [W-1:0] va [4] = '{8'h03, 8'h00, 8'h80, 8'hFF};
        logic [W-1:0] vb [4] = '{8'h05, 8'h00, 8'h01, 8'hFF};
        logic         vi [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] ed [4] = '{8'hFE, 8'hFF, 8'h7F, 8'hFF};
        logic         eb [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int done_at, busy_cyc, pulses, d_changes;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vi[i], done_at, busy_cyc, pulses, d_changes);
            total_cnt++; if (d !== ed[i] || bo !== eb[i])
                $display("FAIL borrow_vec%0d got d=%h bo=%b exp d=%h bo=%b", i, d, bo, ed[i], eb[i]); else pass_cnt++;
            total_cnt++; if (done_at != 9 || pulses != 1 || d_changes != 0)
                $display("FAIL borrow_timing%0d got done_at=%0d pulses=%0d dchg=%0d exp 9/1/0", i, done_at, pulses, d_changes); else pass_cnt++;
            $display("borrow: %h-%h-%b -> d=%h bo=%b", va[i], vb[i], vi[i], d, bo);
        end
    endtask

    task automatic test_ignore_start();
        int done_at = 0;
        int pulses  = 0;
        @(negedge clk);
        a = 8'h5A; b = 8'h23; bi = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'h00; bi = 1'b1;
            end
            if (done) begin
                pulses++;
                if (done_at == 0) done_at = k;
            end
        end
        total_cnt++; if (pulses != 1) $display("FAIL ignore_pulses got %0d exp 1", pulses); else pass_cnt++;
        total_cnt++; if (done_at != 9) $display("FAIL ignore_latency got %0d exp 9", done_at); else pass_cnt++;
        total_cnt++; if (d !== 8'h37 || bo !== 1'b0)
            $display("FAIL ignore_result got d=%h bo=%b exp d=37 bo=0", d, bo); else pass_cnt++;
        $display("ignore_start: 5A-23-0 -> d=%h bo=%b pulses=%0d", d, bo, pulses);
    endtask

    task automatic test_async_reset();
        int pulses  = 0;
        int done_at = 0;
        @(negedge clk);
        a = 8'h12; b = 8'h34; bi = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total_cnt++; if (d !== 8'h00 || bo !== 1'b0)
            $display("FAIL async_reset_out got d=%h bo=%b exp d=00 bo=0", d, bo); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL async_reset_ctl got busy=%b done=%b exp 0/0", busy, done); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        total_cnt++; if (pulses != 0) $display("FAIL abort_no_done got %0d active cycles exp 0", pulses); else pass_cnt++;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; a = 8'h34; b = 8'h12; bi = 1'b0; start = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                pulses++;
                if (done_at == 0) done_at = k;
            end
        end
        total_cnt++; if (done_at != 9 || pulses != 1)
            $display("FAIL post_reset_latency got done_at=%0d pulses=%0d exp 9/1", done_at, pulses); else pass_cnt++;
        total_cnt++; if (d !== 8'h22 || bo !== 1'b0)
            $display("FAIL post_reset_result got d=%h bo=%b exp d=22 bo=0", d, bo); else pass_cnt++;
        $display("async_reset: post-reset 34-12-0 -> d=%h bo=%b done_at=%0d", d, bo, done_at);
    endtask

    task automatic test_back_to_back();
        int           at   [4];
        logic [W-1:0] dval [4];
        logic         bval [4];
        int           pulses = 0;
        int           viol   = 0;
        @(negedge clk);
        a = 8'h10; b = 8'h01; bi = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                if (pulses < 4) begin
                    at[pulses]   = k;
                    dval[pulses] = d;
                    bval[pulses] = bo;
                end
                pulses++;
                if (pulses == 1) begin a = 8'h20; b = 8'h30; bi = 1'b0; end
                if (pulses == 2) begin a = 8'h77; b = 8'h77; bi = 1'b1; end
            end else if (pulses > 0 && pulses <= 4 && d !== dval[pulses-1]) begin
                viol++;
            end
            if (k == 21) start = 1'b0;
        end
        total_cnt++; if (pulses != 3) $display("FAIL b2b_pulses got %0d exp 3", pulses); else pass_cnt++;
        if (pulses == 3) begin
            total_cnt++; if (at[1] - at[0] != 10 || at[2] - at[1] != 10)
                $display("FAIL b2b_period got %0d,%0d exp 10,10", at[1] - at[0], at[2] - at[1]); else pass_cnt++;
            total_cnt++; if (dval[0] !== 8'h0F || bval[0] !== 1'b0)
                $display("FAIL b2b_op1 got d=%h bo=%b exp d=0F bo=0", dval[0], bval[0]); else pass_cnt++;
            total_cnt++; if (dval[1] !== 8'hF0 || bval[1] !== 1'b1)
                $display("FAIL b2b_op2 got d=%h bo=%b exp d=F0 bo=1", dval[1], bval[1]); else pass_cnt++;
            total_cnt++; if (dval[2] !== 8'hFF || bval[2] !== 1'b1)
                $display("FAIL b2b_op3 got d=%h bo=%b exp d=FF bo=1", dval[2], bval[2]); else pass_cnt++;
        end
        total_cnt++; if (viol != 0) $display("FAIL b2b_d_stable got %0d changes exp 0", viol); else pass_cnt++;
        $display("back_to_back: pulses=%0d violations=%0d", pulses, viol);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
